// File: rtl/cpx_fsl_pkg.sv
// Shared constants and types for the CPX return-path assembler.
package cpx_fsl_pkg;

  localparam int CPX_W       = 145;
  localparam int CPX_VLD_BIT = 144;
  localparam int FSL_W       = 32;
  localparam int CPX_WORDS   = 5;
  localparam int HDR_W       = CPX_W - 4 * FSL_W;  // 17 header bits carried by word0

  // Assembler control state
  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } fsm_state_e;

  // CPX return-type field, packet bits [143:140]
  localparam logic [3:0] CPX_RTYPE_LOAD  = 4'h0;
  localparam logic [3:0] CPX_RTYPE_IFILL = 4'h1;
  localparam logic [3:0] CPX_RTYPE_INV   = 4'h3;
  localparam logic [3:0] CPX_RTYPE_STACK = 4'h4;
  localparam logic [3:0] CPX_RTYPE_INT   = 4'h7;
  localparam logic [3:0] CPX_RTYPE_FP    = 4'h8;

endpackage

// File: rtl/fsl_cpx_assembler.sv
// Assembles 145-bit CPX packets from five 32-bit FSL words and pulses them
// onto the core's CPX input, keeping at least MIN_GAP idle cycles between
// packets. One packet can wait in a pending slot; while it waits, the final
// word of the next packet is left in the FSL FIFO.
module fsl_cpx_assembler
  import cpx_fsl_pkg::*;
#(
  parameter int MIN_GAP = 2,
  parameter int ERR_W   = 8
) (
  input  logic             rclk,
  input  logic             rst_l,
  input  logic [FSL_W-1:0] fsl_s_data,
  input  logic             fsl_s_control,
  input  logic             fsl_s_exists,
  output logic             fsl_s_read,
  output logic [CPX_W-1:0] cpx_spc_data_cx2,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP);

  fsm_state_e        state_reg, state_next;
  logic [2:0]        word_cnt_reg, word_cnt_next;
  logic [HDR_W-1:0]  hdr_reg, hdr_next;
  logic [3*FSL_W-1:0] body_reg, body_next;   // words 1..3, word1 in the top slice
  logic              pend_valid_reg, pend_valid_next;
  logic [CPX_W-1:0]  pend_reg, pend_next;
  logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
  logic [CPX_W-1:0]  cpx_reg, cpx_next;
  logic [ERR_W-1:0]  err_reg, err_next;

  logic             accept;
  logic             pkt_done;
  logic             pkt_ok;
  logic             err_inc;
  logic             gap_zero;
  logic             emit_pend;
  logic             emit_direct;
  logic [CPX_W-1:0] pkt_asm;

  // Hold back the last word of a packet while the pending slot is occupied
  assign fsl_s_read = fsl_s_exists &&
                      !(state_reg == COLLECT && word_cnt_reg == 3'd4 && pend_valid_reg);
  assign accept     = fsl_s_exists && fsl_s_read;
  assign pkt_asm    = {hdr_reg, body_reg, fsl_s_data};

  // Framing: header/data sequencing, word placement and error detection
  always_comb begin
    state_next    = state_reg;
    word_cnt_next = word_cnt_reg;
    hdr_next      = hdr_reg;
    body_next     = body_reg;
    pkt_done      = 1'b0;
    err_inc       = 1'b0;
    if (accept) begin
      if (fsl_s_control) begin
        // A header always restarts assembly; mid-packet it abandons the partial one
        err_inc       = (state_reg == COLLECT);
        hdr_next      = fsl_s_data[HDR_W-1:0];
        word_cnt_next = 3'd1;
        state_next    = COLLECT;
      end else if (state_reg == IDLE) begin
        err_inc = 1'b1;
      end else if (word_cnt_reg == 3'd4) begin
        pkt_done      = 1'b1;
        err_inc       = !pkt_asm[CPX_VLD_BIT];
        word_cnt_next = 3'd0;
        state_next    = IDLE;
      end else begin
        case (word_cnt_reg)
          3'd1:    body_next[3*FSL_W-1:2*FSL_W] = fsl_s_data;
          3'd2:    body_next[2*FSL_W-1:FSL_W]   = fsl_s_data;
          default: body_next[FSL_W-1:0]         = fsl_s_data;
        endcase
        word_cnt_next = word_cnt_reg + 3'd1;
      end
    end
  end

  assign pkt_ok      = pkt_done && pkt_asm[CPX_VLD_BIT];
  assign gap_zero    = (gap_cnt_reg == '0);
  assign emit_pend   = pend_valid_reg && gap_zero;
  assign emit_direct = pkt_ok && !pend_valid_reg && gap_zero;

  // Output pulse, pending slot, gap spacing and saturating error count
  always_comb begin
    cpx_next        = '0;
    pend_next       = pend_reg;
    pend_valid_next = pend_valid_reg;
    gap_cnt_next    = gap_cnt_reg;
    err_next        = err_reg;
    if (emit_pend) begin
      cpx_next = pend_reg;
    end else if (emit_direct) begin
      cpx_next = pkt_asm;
    end
    // A packet that cannot go straight out takes the slot; pending drains first
    if (pkt_ok && !emit_direct) begin
      pend_next       = pkt_asm;
      pend_valid_next = 1'b1;
    end else if (emit_pend) begin
      pend_valid_next = 1'b0;
    end
    if (emit_pend || emit_direct) begin
      gap_cnt_next = GAP_LOAD;
    end else if (!gap_zero) begin
      gap_cnt_next = gap_cnt_reg - 1'b1;
    end
    if (err_inc && err_reg != '1) begin
      err_next = err_reg + 1'b1;
    end
  end

  // State registers; reset discards any partial or pending packet
  always_ff @(posedge rclk or negedge rst_l) begin
    if (!rst_l) begin
      state_reg      <= IDLE;
      word_cnt_reg   <= '0;
      hdr_reg        <= '0;
      body_reg       <= '0;
      pend_valid_reg <= 1'b0;
      pend_reg       <= '0;
      gap_cnt_reg    <= '0;
      cpx_reg        <= '0;
      err_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      word_cnt_reg   <= word_cnt_next;
      hdr_reg        <= hdr_next;
      body_reg       <= body_next;
      pend_valid_reg <= pend_valid_next;
      pend_reg       <= pend_next;
      gap_cnt_reg    <= gap_cnt_next;
      cpx_reg        <= cpx_next;
      err_reg        <= err_next;
    end
  end

  assign cpx_spc_data_cx2 = cpx_reg;
  assign err_cnt          = err_reg;

endmodule

// File: tb/tb_fsl_cpx_assembler.sv
// Randomized bench for fsl_cpx_assembler: three instances with different
// MIN_GAP values consume one shared word stream, each against its own
// transaction-level reference (packet parse + earliest-allowed emission).
module tb_fsl_cpx_assembler;
  import cpx_fsl_pkg::*;

  localparam int NL = 3;
  localparam logic [144:0] P1_EXP =
    {17'h18000, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

  logic rclk  = 1'b0;
  logic rst_l = 1'b1;
  always #5 rclk = ~rclk;

  logic [32:0] stim_q[$];   // {control, data}
  int          phase     = 0;
  bit          rand_idle = 1'b0;
  int          total     = 0;
  int          bad       = 0;

  // Single comparison point for the whole bench
  task automatic chk(input string tag, input logic [144:0] got, input logic [144:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < NL; gi++) begin : lane
    localparam int GAP = (gi == 0) ? 2 : ((gi == 1) ? 0 : 12);
    logic [31:0]  s_data   = '0;
    logic         s_ctrl   = 1'b0;
    logic         s_exists = 1'b0;
    logic         s_read;
    logic [144:0] cpx;
    logic [7:0]   err;
    int           idx        = 0;
    int           seen_phase = 0;
    bit           acc        = 1'b0;
    bit           done       = 1'b1;
    // reference model state
    logic [16:0]  m_hdr;
    logic [31:0]  m_w[4];
    int           m_cnt   = 0;
    bit           m_in    = 1'b0;
    logic [144:0] m_wait[$];
    int           m_err   = 0;
    int           m_since = 1000;

    fsl_cpx_assembler #(.MIN_GAP(GAP), .ERR_W(8)) u_dut (
      .rclk             (rclk),
      .rst_l            (rst_l),
      .fsl_s_data       (s_data),
      .fsl_s_control    (s_ctrl),
      .fsl_s_exists     (s_exists),
      .fsl_s_read       (s_read),
      .cpx_spc_data_cx2 (cpx),
      .err_cnt          (err)
    );

    // Per-cycle model step, output checks, then drive of the next word
    always @(negedge rclk) begin
      logic [144:0] exp_out;
      logic [144:0] pkt;
      logic [32:0]  w;
      bit           rd_exp;
      if (!rst_l) begin
        m_cnt = 0; m_in = 1'b0; m_wait.delete(); m_err = 0; m_since = 1000;
        acc = 1'b0; s_exists = 1'b0; done = 1'b1;
      end else begin
        exp_out = '0;
        if (acc) begin
          w = stim_q[idx];
          idx++;
          if (w[32]) begin
            if (m_in && m_err < 255) m_err++;
            m_hdr = w[16:0]; m_cnt = 1; m_in = 1'b1;
          end else if (!m_in) begin
            if (m_err < 255) m_err++;
          end else begin
            m_w[m_cnt-1] = w[31:0];
            m_cnt++;
            if (m_cnt == 5) begin
              pkt  = {m_hdr, m_w[0], m_w[1], m_w[2], m_w[3]};
              m_in = 1'b0; m_cnt = 0;
              if (pkt[144]) m_wait.push_back(pkt);
              else if (m_err < 255) m_err++;
            end
          end
        end
        if (m_since < 1000) m_since++;
        if (m_wait.size() > 0 && m_since > GAP) begin
          exp_out = m_wait.pop_front();
          m_since = 0;
          $display("emit lane=%0d pkt=%h", gi, exp_out);
        end
        chk($sformatf("lane%0d_cpx", gi), cpx, exp_out);
        chk($sformatf("lane%0d_err", gi), 145'(err), 145'(m_err));
        if (seen_phase != phase) begin
          idx = 0; seen_phase = phase;
        end
        s_exists = (idx < stim_q.size()) && !(rand_idle && $urandom_range(3) == 0);
        if (idx < stim_q.size()) begin
          s_ctrl = stim_q[idx][32];
          s_data = stim_q[idx][31:0];
        end
        #1;
        rd_exp = s_exists && !(m_in && m_cnt == 4 && m_wait.size() > 0);
        chk($sformatf("lane%0d_read", gi), 145'(s_read), 145'(rd_exp));
        acc  = s_exists && s_read;
        done = (idx >= stim_q.size()) && !acc && (m_wait.size() == 0);
      end
    end
  end

  function automatic bit all_done();
    return lane[0].done && lane[1].done && lane[2].done;
  endfunction

  function automatic bit all_fed();
    return lane[0].idx >= stim_q.size() && lane[1].idx >= stim_q.size() &&
           lane[2].idx >= stim_q.size();
  endfunction

  task automatic push_pkt(input bit vld, input int ndata);
    logic [31:0] hdr;
    logic [3:0]  rt;
    hdr = $urandom;
    case ($urandom_range(3))
      0:       rt = CPX_RTYPE_LOAD;
      1:       rt = CPX_RTYPE_IFILL;
      2:       rt = CPX_RTYPE_STACK;
      default: rt = CPX_RTYPE_INT;
    endcase
    hdr[15:12] = rt;
    hdr[16]    = vld;
    stim_q.push_back({1'b1, hdr});
    for (int k = 0; k < ndata; k++) stim_q.push_back({1'b0, 32'($urandom)});
  endtask

  task automatic begin_phase();
    @(posedge rclk);
    #2;
    stim_q.delete();
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge rclk);
      #3;
      ok = all_done();
    end
    chk(tag, 145'(ok), 145'(1));
    repeat (16) @(posedge rclk);
  endtask

  initial begin
    bit seen;
    // async reset at power-up
    #2 rst_l = 1'b0;
    #1;
    chk("rst_cpx", lane[0].cpx, '0);
    chk("rst_err", 145'(lane[0].err), '0);
    chk("rst_read", 145'(lane[0].s_read), '0);
    repeat (3) @(posedge rclk);
    #2 rst_l = 1'b1;

    // single known packet
    begin_phase();
    stim_q.push_back({1'b1, 32'h0001_8000});
    stim_q.push_back({1'b0, 32'h11111111});
    stim_q.push_back({1'b0, 32'h22222222});
    stim_q.push_back({1'b0, 32'h33333333});
    stim_q.push_back({1'b0, 32'h44444444});
    phase++;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge rclk);
      #2;
      seen = lane[0].cpx[144];
    end
    chk("p1_pkt", lane[0].cpx, P1_EXP);
    @(negedge rclk);
    #2;
    chk("p1_pulse", lane[0].cpx, '0);
    wait_idle("p1_idle");
    chk("p1_err", 145'(lane[0].err), 145'(0));

    // back-to-back packets with exists held high
    begin_phase();
    for (int p = 0; p < 4; p++) push_pkt(1'b1, 4);
    phase++;
    wait_idle("b2b_idle");

    // stray header: partial packet dropped, second packet kept
    begin_phase();
    push_pkt(1'b1, 2);
    push_pkt(1'b1, 4);
    phase++;
    wait_idle("stray_idle");
    chk("stray_err", 145'(lane[0].err), 145'(1));

    // leading data word in IDLE, then a packet with the valid bit clear
    begin_phase();
    stim_q.push_back({1'b0, 32'hDEAD_BEEF});
    push_pkt(1'b0, 4);
    phase++;
    wait_idle("inval_idle");
    chk("inval_err", 145'(lane[1].err), 145'(3));

    // random mix with random FIFO bubbles
    begin_phase();
    rand_idle = 1'b1;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(9))
        0:       stim_q.push_back({1'b0, 32'($urandom)});
        1:       push_pkt(1'b0, 4);
        2:       push_pkt(1'b1, $urandom_range(3));
        default: push_pkt(1'b1, 4);
      endcase
    end
    phase++;
    wait_idle("rand_idle");
    rand_idle = 1'b0;

    // reset with a partial packet collected and (slow lane) one pending
    begin_phase();
    stim_q.push_back({1'b0, 32'h0});
    push_pkt(1'b1, 4);
    push_pkt(1'b1, 4);
    push_pkt(1'b1, 2);
    phase++;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge rclk);
      #3;
      seen = all_fed();
    end
    chk("rst_fed", 145'(seen), 145'(1));
    #2 rst_l = 1'b0;
    #1;
    for (int l = 0; l < NL; l++) begin
      logic [144:0] c_v;
      logic [7:0]   e_v;
      c_v = (l == 0) ? lane[0].cpx : ((l == 1) ? lane[1].cpx : lane[2].cpx);
      e_v = (l == 0) ? lane[0].err : ((l == 1) ? lane[1].err : lane[2].err);
      chk($sformatf("mid_rst_cpx%0d", l), c_v, '0);
      chk($sformatf("mid_rst_err%0d", l), 145'(e_v), '0);
    end
    repeat (3) @(posedge rclk);
    #2 rst_l = 1'b1;

    // fresh packet after reset (pending packet must not reappear)
    begin_phase();
    push_pkt(1'b1, 4);
    phase++;
    wait_idle("post_rst_idle");
    chk("post_rst_err", 145'(lane[2].err), 145'(0));

    // error counter saturation
    begin_phase();
    for (int i = 0; i < 300; i++) stim_q.push_back({1'b0, 32'($urandom)});
    phase++;
    wait_idle("sat_idle");
    chk("sat_err0", 145'(lane[0].err), 145'(8'hFF));
    chk("sat_err2", 145'(lane[2].err), 145'(8'hFF));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
